// File: rtl/rv_bpu.sv
// Branch prediction unit: PC-indexed table of saturating counters with registered IF lookup
// and EX-stage resolution. Define RV_BPU_BTB_EN to add a tagged branch target buffer.
module rv_bpu #(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 2,
  parameter int TAG_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_taken_o,
  output logic [XLEN-1:0] if_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            ex_mispredict_o,
  output logic [XLEN-1:0] ex_redirect_pc_o,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispred_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  // Weakly-not-taken: MSB clear, all lower bits set (zero when CNT_W is 1).
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [BHT_DEPTH];
  logic             r_taken;
  logic [XLEN-1:0]  r_target;
  logic [31:0]      r_perf_br;
  logic [31:0]      r_perf_mp;

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_ex_branch;
  logic             w_ex_alias;
  logic             w_mispredict;
  logic             w_pred_taken;
  logic [XLEN-1:0]  w_pred_target;
  logic             w_unused_pc;

  assign w_if_idx    = if_pc_i[IDX_W+1:2];
  assign w_ex_idx    = ex_pc_i[IDX_W+1:2];
  assign w_ex_branch = ex_valid_i & ex_is_branch_i;
  assign w_ex_alias  = ex_valid_i & ~ex_is_branch_i & ex_pred_taken_i;
  assign w_unused_pc = ^if_pc_i;

  assign w_mispredict = (w_ex_branch & ((ex_taken_i != ex_pred_taken_i) |
                        (ex_taken_i & (ex_target_i != ex_pred_target_i)))) | w_ex_alias;

  assign ex_mispredict_o  = w_mispredict;
  assign ex_redirect_pc_o = (ex_taken_i & ex_is_branch_i) ? ex_target_i : ex_pc_i + XLEN'(4);

`ifdef RV_BPU_BTB_EN
  logic             r_btb_v   [BHT_DEPTH];
  logic [TAG_W-1:0] r_btb_tag [BHT_DEPTH];
  logic [XLEN-1:0]  r_btb_tgt [BHT_DEPTH];
  logic [TAG_W-1:0] w_if_tag;
  logic [TAG_W-1:0] w_ex_tag;

  assign w_if_tag      = if_pc_i[IDX_W+2 +: TAG_W];
  assign w_ex_tag      = ex_pc_i[IDX_W+2 +: TAG_W];
  assign w_pred_taken  = r_cnt[w_if_idx][CNT_W-1] & r_btb_v[w_if_idx] &
                         (r_btb_tag[w_if_idx] == w_if_tag);
  assign w_pred_target = r_btb_tgt[w_if_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_btb_v[i]   <= 1'b0;
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
      end
    end else if (w_ex_branch && ex_taken_i) begin
      r_btb_v[w_ex_idx]   <= 1'b1;
      r_btb_tag[w_ex_idx] <= w_ex_tag;
      r_btb_tgt[w_ex_idx] <= ex_target_i;
    end else if (w_ex_alias) begin
      r_btb_v[w_ex_idx] <= 1'b0;
    end
  end
`else
  assign w_pred_taken  = r_cnt[w_if_idx][CNT_W-1];
  assign w_pred_target = '0;
`endif

  // Lookup registers hold while IF is stalled; updates below never wait on if_valid_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken  <= 1'b0;
      r_target <= '0;
    end else if (if_valid_i) begin
      r_taken  <= w_pred_taken;
      r_target <= w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_cnt[i] <= CNT_RST;
    end else if (w_ex_branch) begin
      if (ex_taken_i) begin
        if (r_cnt[w_ex_idx] != CNT_MAX) r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + CNT_W'(1);
      end else begin
        if (r_cnt[w_ex_idx] != '0) r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_br <= '0;
      r_perf_mp <= '0;
    end else begin
      if (w_ex_branch && (r_perf_br != 32'hFFFF_FFFF)) r_perf_br <= r_perf_br + 32'd1;
      if (w_mispredict && (r_perf_mp != 32'hFFFF_FFFF)) r_perf_mp <= r_perf_mp + 32'd1;
    end
  end

  assign if_taken_o      = r_taken;
  assign if_target_o     = r_target;
  assign perf_branches_o = r_perf_br;
  assign perf_mispred_o  = r_perf_mp;

endmodule
